// File: rtl/companion_action_unit_if.sv
// Action handshake between the companion menu FSM and the action unit.
// The FSM side (master) issues an action code and holds exec high; the
// unit side (slave) reports completion and whether it is occupied.
interface companion_action_unit_if;
    logic [1:0] selected;
    logic       exec;
    logic       exec_status;
    logic       busy;

    modport master (
        output selected,
        output exec,
        input  exec_status,
        input  busy
    );

    modport slave (
        input  selected,
        input  exec,
        output exec_status,
        output busy
    );
endinterface

// File: rtl/companion_action_unit.sv
// Companion action unit: runs the action chosen by the menu FSM for a fixed
// number of cycles, applies a saturating gain to the targeted stat, and
// decays all three pet stats on a free-running period.
module companion_action_unit #(
    parameter int STAT_WIDTH    = 4,
    parameter int ACTION_CYCLES = 8,
    parameter int DECAY_PERIOD  = 16,
    parameter int GAIN          = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    companion_action_unit_if.slave act,
    output logic [STAT_WIDTH-1:0] fullness,
    output logic [STAT_WIDTH-1:0] happiness,
    output logic [STAT_WIDTH-1:0] cleanliness,
    output logic                  needs_attention
);

    // Counter widths; a single-cycle action still needs a 1-bit counter.
    localparam int SW1   = STAT_WIDTH + 1;
    localparam int CNT_W = (ACTION_CYCLES > 1) ? $clog2(ACTION_CYCLES) : 1;
    localparam int PRE_W = $clog2(DECAY_PERIOD);

    // The gain sum is done one bit wider so it can be clamped, not wrapped.
    localparam logic [SW1-1:0]        STAT_MAX_W = {1'b0, {STAT_WIDTH{1'b1}}};
    localparam logic [SW1-1:0]        GAIN_W     = SW1'(GAIN);
    localparam logic [STAT_WIDTH-1:0] STAT_ONE   = STAT_WIDTH'(1);
    localparam logic [CNT_W-1:0]      CNT_LOAD   = CNT_W'(ACTION_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
    localparam logic [PRE_W-1:0]      PRE_LAST   = PRE_W'(DECAY_PERIOD - 1);
    localparam logic [PRE_W-1:0]      PRE_ONE    = PRE_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'b00,
        ACT_FEED  = 2'b01,
        ACT_PLAY  = 2'b10,
        ACT_CLEAN = 2'b11
    } action_t;

    state_t                state_q, state_d;
    action_t               act_q, act_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [STAT_WIDTH-1:0] fullness_q, fullness_d;
    logic [STAT_WIDTH-1:0] happiness_q, happiness_d;
    logic [STAT_WIDTH-1:0] cleanliness_q, cleanliness_d;

    logic                  tick;
    logic                  gain_now;
    logic [STAT_WIDTH-1:0] fullness_base;
    logic [STAT_WIDTH-1:0] happiness_base;
    logic [STAT_WIDTH-1:0] cleanliness_base;

    // Stat minus one, floored at zero.
    function automatic logic [STAT_WIDTH-1:0] sat_dec(input logic [STAT_WIDTH-1:0] s);
        if (s == '0) begin
            sat_dec = '0;
        end else begin
            sat_dec = s - STAT_ONE;
        end
    endfunction

    // Stat plus GAIN, clamped at the stat maximum.
    function automatic logic [STAT_WIDTH-1:0] sat_gain(input logic [STAT_WIDTH-1:0] s);
        logic [SW1-1:0] sum;
        sum = {1'b0, s} + GAIN_W;
        if (sum > STAT_MAX_W) begin
            sat_gain = STAT_MAX_W[STAT_WIDTH-1:0];
        end else begin
            sat_gain = sum[STAT_WIDTH-1:0];
        end
    endfunction

    // State, latched action, action counter, prescaler and stat registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            act_q         <= ACT_NONE;
            cnt_q         <= '0;
            pre_q         <= '0;
            fullness_q    <= '1;
            happiness_q   <= '1;
            cleanliness_q <= '1;
        end else begin
            state_q       <= state_d;
            act_q         <= act_d;
            cnt_q         <= cnt_d;
            pre_q         <= pre_d;
            fullness_q    <= fullness_d;
            happiness_q   <= happiness_d;
            cleanliness_q <= cleanliness_d;
        end
    end

    // Next state plus counter/latch updates; RUN ignores exec so a drop cannot abort.
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (act.exec) begin
                    if (act.selected != ACT_NONE) begin
                        act_d   = action_t'(act.selected);
                        cnt_d   = CNT_LOAD;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!act.exec) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        act.exec_status = (state_q == ST_DONE);
        act.busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
    end

    // Free-running decay prescaler, wrapping at DECAY_PERIOD-1.
    always_comb begin
        tick  = (pre_q == PRE_LAST);
        pre_d = tick ? '0 : (pre_q + PRE_ONE);
    end

    // Stats decay first, then the target stat of a finishing action takes the gain.
    always_comb begin
        gain_now         = (state_q == ST_RUN) && (cnt_q == '0);
        fullness_base    = tick ? sat_dec(fullness_q)    : fullness_q;
        happiness_base   = tick ? sat_dec(happiness_q)   : happiness_q;
        cleanliness_base = tick ? sat_dec(cleanliness_q) : cleanliness_q;
        fullness_d       = fullness_base;
        happiness_d      = happiness_base;
        cleanliness_d    = cleanliness_base;
        if (gain_now) begin
            case (act_q)
                ACT_FEED:  fullness_d    = sat_gain(fullness_base);
                ACT_PLAY:  happiness_d   = sat_gain(happiness_base);
                ACT_CLEAN: cleanliness_d = sat_gain(cleanliness_base);
                default:   fullness_d    = fullness_base;
            endcase
        end
    end

    assign fullness        = fullness_q;
    assign happiness       = happiness_q;
    assign cleanliness     = cleanliness_q;
    assign needs_attention = (fullness_q == '0) || (happiness_q == '0) || (cleanliness_q == '0);

endmodule

// File: tb/tb_companion_action_unit.sv
// Bench for companion_action_unit: directed actions with a completion
// scoreboard, plus direct checks of reset, decay, floor and abort behaviour.
module tb_companion_action_unit;

    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // 10-unit clock period.
    always #5 clk = ~clk;

    companion_action_unit_if bus ();
    companion_action_unit_if bus_floor ();

    logic [SW-1:0] fullness, happiness, cleanliness;
    logic          needs_attention;
    logic [SW-1:0] fl_full, fl_happy, fl_clean;
    logic          fl_needs;

    companion_action_unit #(
        .STAT_WIDTH(4), .ACTION_CYCLES(8), .DECAY_PERIOD(16), .GAIN(4)
    ) dut (
        .clk(clk), .rst(rst), .act(bus),
        .fullness(fullness), .happiness(happiness), .cleanliness(cleanliness),
        .needs_attention(needs_attention)
    );

    companion_action_unit #(
        .STAT_WIDTH(4), .ACTION_CYCLES(8), .DECAY_PERIOD(2), .GAIN(4)
    ) dut_floor (
        .clk(clk), .rst(rst), .act(bus_floor),
        .fullness(fl_full), .happiness(fl_happy), .cleanliness(fl_clean),
        .needs_attention(fl_needs)
    );

    typedef struct {
        int        edge_no;
        logic [3:0] f;
        logic [3:0] h;
        logic [3:0] c;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_cnt;
    logic status_prev;

    // Edge number relative to the last reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic exec_v, input logic [1:0] sel_v);
        bus.exec     = exec_v;
        bus.selected = sel_v;
    endtask

    task automatic push_expect(input int e, input int f, input int h, input int c);
        exp_t x;
        x.edge_no = e;
        x.f = 4'(f);
        x.h = 4'(h);
        x.c = 4'(c);
        exp_q.push_back(x);
    endtask

    task automatic wait_edge(input int n);
        int guard;
        guard = 0;
        while (edge_cnt != n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (edge_cnt != n) checkOutput("wait_edge_timeout", edge_cnt, n);
    endtask

    task automatic wait_status(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (bus.exec_status) return;
            @(negedge clk);
        end
        checkOutput("exec_status_timeout", bus.exec_status, 1);
    endtask

    task automatic check_stats(input string name, input int f, input int h, input int c);
        checkOutput({name, "_fullness"}, fullness, f);
        checkOutput({name, "_happiness"}, happiness, h);
        checkOutput({name, "_cleanliness"}, cleanliness, c);
    endtask

    // Monitor: on each rising exec_status, pop the expected completion and compare.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            status_prev = 1'b0;
        end else begin
            if (bus.exec_status && !status_prev) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("done_edge", edge_cnt, mon_e.edge_no);
                    checkOutput("done_fullness", fullness, mon_e.f);
                    checkOutput("done_happiness", happiness, mon_e.h);
                    checkOutput("done_cleanliness", cleanliness, mon_e.c);
                end
            end
            status_prev = bus.exec_status;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        applyStimulus(1'b0, 2'b00);
        bus_floor.exec     = 1'b0;
        bus_floor.selected = 2'b00;

        // Reset state
        repeat (2) @(negedge clk);
        check_stats("in_reset", 15, 15, 15);
        checkOutput("in_reset_busy", bus.busy, 0);
        rst = 1'b0;
        checkOutput("reset_exec_status", bus.exec_status, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_needs_attention", needs_attention, 0);

        // Saturation: play sampled at edge 1, done at edge 9
        push_expect(9, 15, 15, 15);
        applyStimulus(1'b1, 2'b10);
        wait_edge(1);
        checkOutput("sat_busy", bus.busy, 1);
        checkOutput("sat_status_early", bus.exec_status, 0);
        wait_status(20);
        applyStimulus(1'b0, 2'b00);
        @(negedge clk);
        checkOutput("sat_status_drop", bus.exec_status, 0);
        checkOutput("sat_busy_drop", bus.busy, 0);

        // Decay timing and floor instance
        wait_edge(15);
        check_stats("pre_decay", 15, 15, 15);
        wait_edge(16);
        check_stats("decay16", 14, 14, 14);
        wait_edge(29);
        checkOutput("floor29_fullness", fl_full, 1);
        checkOutput("floor29_needs", fl_needs, 0);
        wait_edge(30);
        checkOutput("floor30_fullness", fl_full, 0);
        checkOutput("floor30_happiness", fl_happy, 0);
        checkOutput("floor30_cleanliness", fl_clean, 0);
        checkOutput("floor30_needs", fl_needs, 1);
        wait_edge(32);
        check_stats("decay32", 13, 13, 13);
        wait_edge(40);
        checkOutput("floor40_fullness", fl_full, 0);
        checkOutput("floor40_needs", fl_needs, 1);

        // Feed sampled at edge 129, done at edge 137
        wait_edge(128);
        check_stats("feed_pre", 7, 7, 7);
        push_expect(137, 11, 7, 7);
        applyStimulus(1'b1, 2'b01);
        wait_edge(129);
        checkOutput("feed_busy129", bus.busy, 1);
        wait_edge(136);
        checkOutput("feed_busy136", bus.busy, 1);
        checkOutput("feed_status136", bus.exec_status, 0);
        checkOutput("feed_full136", fullness, 7);
        wait_status(20);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("feed_hold_status", bus.exec_status, 1);
        end
        applyStimulus(1'b0, 2'b00);
        @(negedge clk);
        checkOutput("feed_release_status", bus.exec_status, 0);
        checkOutput("feed_release_busy", bus.busy, 0);
        check_stats("feed_after", 11, 7, 7);

        // Clean sampled at edge 120 coincides with tick at edge 128
        do_reset();
        wait_edge(119);
        check_stats("clean_pre", 8, 8, 8);
        push_expect(128, 7, 7, 11);
        applyStimulus(1'b1, 2'b11);
        wait_status(20);
        applyStimulus(1'b0, 2'b00);
        @(negedge clk);
        checkOutput("clean_release_status", bus.exec_status, 0);

        // Null action: DONE on the sampling edge, no stat change
        do_reset();
        wait_edge(2);
        push_expect(3, 15, 15, 15);
        applyStimulus(1'b1, 2'b00);
        wait_edge(3);
        checkOutput("null_status", bus.exec_status, 1);
        checkOutput("null_busy", bus.busy, 1);
        applyStimulus(1'b0, 2'b00);
        wait_edge(4);
        checkOutput("null_release_status", bus.exec_status, 0);

        // Abort: reset during RUN, exec held so a fresh action starts at edge 1
        wait_edge(40);
        check_stats("abort_pre", 13, 13, 13);
        applyStimulus(1'b1, 2'b01);
        wait_edge(44);
        checkOutput("abort_busy_before", bus.busy, 1);
        rst = 1'b1;
        #1;
        check_stats("abort_reset", 15, 15, 15);
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_status", bus.exec_status, 0);
        @(negedge clk);
        push_expect(9, 15, 15, 15);
        rst = 1'b0;
        wait_edge(1);
        checkOutput("restart_busy", bus.busy, 1);
        wait_status(20);
        applyStimulus(1'b0, 2'b00);
        wait_edge(15);
        check_stats("restart_pre_decay", 15, 15, 15);
        wait_edge(16);
        check_stats("restart_decay16", 14, 14, 14);

        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
